// File: rtl/wb_arbiter_if.sv
// Bus bundle between the write-back arbiter and its neighbours.
// master: result producers (ALU, memory unit) and register-file consumer side.
// slave : the arbiter itself.
// Signals:
//   alu_valid/alu_ready/alu_rd/alu_data           ALU result handshake
//   ld_valid/ld_ready/ld_rd/ld_funct3/ld_off/ld_word  load result handshake
//   A3/WD3/EN                                     register-file write port
//   pending_mask                                  one bit per register with a write in flight
interface wb_arbiter_if #(
    parameter int unsigned XLEN = 32
);
    logic            alu_valid;
    logic            alu_ready;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;

    logic            ld_valid;
    logic            ld_ready;
    logic [4:0]      ld_rd;
    logic [2:0]      ld_funct3;
    logic [1:0]      ld_off;
    logic [XLEN-1:0] ld_word;

    logic [4:0]      A3;
    logic [XLEN-1:0] WD3;
    logic            EN;
    logic [31:0]     pending_mask;

    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output ld_valid, ld_rd, ld_funct3, ld_off, ld_word,
        input  ld_ready,
        input  A3, WD3, EN, pending_mask
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  ld_valid, ld_rd, ld_funct3, ld_off, ld_word,
        output ld_ready,
        output A3, WD3, EN, pending_mask
    );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges single-cycle ALU results and extended load data into the
// register-file write port (A3/WD3/EN). Loads are extended on entry and held in a small
// in-order queue; the ALU has priority unless the queue head has waited STARVE_MAX cycles.
// Ports:
//   CLK    clock, all state on rising edge
//   RST_N  synchronous reset, active low; also forces both ready outputs low
//   bus    wb_arbiter_if.slave (ALU/load handshakes, A3/WD3/EN, pending_mask)
module wb_arbiter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned LQ_DEPTH   = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input logic         CLK,
    input logic         RST_N,
    wb_arbiter_if.slave bus
);
    localparam int unsigned CntW = $clog2(LQ_DEPTH + 1);
    localparam int unsigned StW  = $clog2(STARVE_MAX + 1);
    localparam logic [CntW-1:0] Depth     = CntW'(LQ_DEPTH);
    localparam logic [StW-1:0]  StarveMax = StW'(STARVE_MAX);

    // Queue is a shift register: slot 0 is the head, slots [0, count_q) are valid.
    logic [XLEN-1:0] data_q [LQ_DEPTH];
    logic [XLEN-1:0] data_d [LQ_DEPTH];
    logic [4:0]      rd_q   [LQ_DEPTH];
    logic [4:0]      rd_d   [LQ_DEPTH];
    logic [CntW-1:0] count_q, count_d, count_popped;
    logic [StW-1:0]  starve_q, starve_d;
    logic            en_q, en_d;
    logic [4:0]      a3_q, a3_d;
    logic [XLEN-1:0] wd3_q, wd3_d;

    logic alu_rdy, ld_rdy, alu_fire, ld_fire, push, pop;
    logic [XLEN-1:0] ld_ext;
    logic [31:0]     pmask;

    function automatic logic [XLEN-1:0] extend_load(input logic [2:0]      funct3,
                                                    input logic [1:0]      off,
                                                    input logic [XLEN-1:0] word);
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] r;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (funct3)
            3'b000:  r = {{(XLEN-8){b[7]}}, b};
            3'b001:  r = {{(XLEN-16){h[15]}}, h};
            3'b100:  r = {{(XLEN-8){1'b0}}, b};
            3'b101:  r = {{(XLEN-16){1'b0}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    always_comb begin
        alu_rdy  = RST_N && (starve_q < StarveMax);
        ld_rdy   = RST_N && (count_q < Depth);
        alu_fire = bus.alu_valid && alu_rdy;
        ld_fire  = bus.ld_valid && ld_rdy;
        // rd=0 loads complete the handshake but are dropped.
        push     = ld_fire && (bus.ld_rd != 5'd0);
        pop      = !alu_fire && (count_q != '0);
        ld_ext   = extend_load(bus.ld_funct3, bus.ld_off, bus.ld_word);

        en_d  = 1'b0;
        a3_d  = a3_q;
        wd3_d = wd3_q;
        if (alu_fire) begin
            if (bus.alu_rd != 5'd0) begin
                en_d  = 1'b1;
                a3_d  = bus.alu_rd;
                wd3_d = bus.alu_data;
            end
        end else if (pop) begin
            en_d  = 1'b1;
            a3_d  = rd_q[0];
            wd3_d = data_q[0];
        end

        starve_d = ((count_q != '0) && !pop) ? starve_q + 1'b1 : '0;

        for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
            data_d[i] = data_q[i];
            rd_d[i]   = rd_q[i];
        end
        if (pop) begin
            for (int unsigned i = 0; i + 1 < LQ_DEPTH; i++) begin
                data_d[i] = data_q[i+1];
                rd_d[i]   = rd_q[i+1];
            end
        end
        count_popped = pop ? count_q - 1'b1 : count_q;
        count_d      = count_popped;
        if (push) begin
            for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
                if (CntW'(i) == count_popped) begin
                    data_d[i] = ld_ext;
                    rd_d[i]   = bus.ld_rd;
                end
            end
            count_d = count_popped + 1'b1;
        end

        pmask = '0;
        for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
            if (CntW'(i) < count_q) pmask[rd_q[i]] = 1'b1;
        end
        if (en_q) pmask[a3_q] = 1'b1;
        pmask[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            count_q  <= '0;
            starve_q <= '0;
            en_q     <= 1'b0;
            a3_q     <= '0;
            wd3_q    <= '0;
            for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
                data_q[i] <= '0;
                rd_q[i]   <= '0;
            end
        end else begin
            count_q  <= count_d;
            starve_q <= starve_d;
            en_q     <= en_d;
            a3_q     <= a3_d;
            wd3_q    <= wd3_d;
            for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
                data_q[i] <= data_d[i];
                rd_q[i]   <= rd_d[i];
            end
        end
    end

    assign bus.alu_ready    = alu_rdy;
    assign bus.ld_ready     = ld_rdy;
    assign bus.A3           = a3_q;
    assign bus.WD3          = wd3_q;
    assign bus.EN           = en_q;
    assign bus.pending_mask = pmask;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios with literal expectations, then random traffic,
// with every cycle compared against a queue-based reference model.
module tb_wb_arbiter;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned LQ_DEPTH   = 2;
    localparam int unsigned STARVE_MAX = 4;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;

    wb_arbiter_if #(.XLEN(XLEN)) bus ();

    wb_arbiter #(
        .XLEN      (XLEN),
        .LQ_DEPTH  (LQ_DEPTH),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    entry_t      m_q[$];
    int          m_starve = 0;
    logic        m_en     = 1'b0;
    logic [4:0]  m_a3     = '0;
    logic [31:0] m_wd3    = '0;
    bit          model_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_ext(input logic [2:0] f, input logic [1:0] off,
                                            input logic [31:0] w);
        int unsigned b;
        int unsigned h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * off[1])) & 32'hFFFF;
        case (f)
            3'd0:    return (b >= 128) ? 32'(int'(b) - 256) : 32'(b);
            3'd1:    return (h >= 32768) ? 32'(int'(h) - 65536) : 32'(h);
            3'd4:    return 32'(b);
            3'd5:    return 32'(h);
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_mask();
        logic [31:0] m;
        m = '0;
        foreach (m_q[i]) m = m | (32'd1 << m_q[i].rd);
        if (m_en) m = m | (32'd1 << m_a3);
        m[0] = 1'b0;
        return m;
    endfunction

    // Reference model: one step per rising edge, using the inputs held across that edge.
    task automatic model_step();
        bit     a_rdy, l_rdy, a_fire, l_fire, nonempty, popped;
        entry_t e;
        model_on = 1'b1;
        if (!RST_N) begin
            m_q.delete();
            m_starve = 0;
            m_en     = 1'b0;
            m_a3     = '0;
            m_wd3    = '0;
            return;
        end
        a_rdy    = m_starve < STARVE_MAX;
        l_rdy    = m_q.size() < LQ_DEPTH;
        a_fire   = bus.alu_valid && a_rdy;
        l_fire   = bus.ld_valid && l_rdy;
        nonempty = m_q.size() > 0;
        popped   = 1'b0;
        m_en     = 1'b0;
        if (a_fire) begin
            if (bus.alu_rd != 0) begin
                m_en  = 1'b1;
                m_a3  = bus.alu_rd;
                m_wd3 = bus.alu_data;
            end
        end else if (nonempty) begin
            e      = m_q.pop_front();
            m_en   = 1'b1;
            m_a3   = e.rd;
            m_wd3  = e.data;
            popped = 1'b1;
        end
        m_starve = (nonempty && !popped) ? m_starve + 1 : 0;
        if (l_fire && bus.ld_rd != 0) begin
            e.rd   = bus.ld_rd;
            e.data = ref_ext(bus.ld_funct3, bus.ld_off, bus.ld_word);
            m_q.push_back(e);
        end
    endtask

    initial forever begin
        @(posedge CLK);
        model_step();
    end

    initial forever begin
        @(negedge CLK);
        if (model_on) begin
            chk("alu_ready", 32'(bus.alu_ready), 32'(RST_N && (m_starve < STARVE_MAX)));
            chk("ld_ready", 32'(bus.ld_ready), 32'(RST_N && (m_q.size() < LQ_DEPTH)));
            chk("EN", 32'(bus.EN), 32'(m_en));
            chk("A3", 32'(bus.A3), 32'(m_a3));
            chk("WD3", bus.WD3, m_wd3);
            chk("pending_mask", bus.pending_mask, ref_mask());
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0;
        bus.ld_valid  = 1'b0;
    endtask

    task automatic set_alu(input logic [4:0] rd, input logic [31:0] data);
        bus.alu_valid = 1'b1;
        bus.alu_rd    = rd;
        bus.alu_data  = data;
    endtask

    task automatic set_ld(input logic [4:0] rd, input logic [2:0] f, input logic [1:0] off,
                          input logic [31:0] w);
        bus.ld_valid  = 1'b1;
        bus.ld_rd     = rd;
        bus.ld_funct3 = f;
        bus.ld_off    = off;
        bus.ld_word   = w;
    endtask

    // Single load into an idle arbiter: accepted on one edge, written back on the next.
    task automatic load_case(input string name, input logic [2:0] f, input logic [1:0] off,
                             input logic [31:0] w, input logic [31:0] exp);
        set_ld(5'd3, f, off, w);
        tick();
        idle();
        tick();
        chk({name, " EN"}, 32'(bus.EN), 32'd1);
        chk({name, " WD3"}, bus.WD3, exp);
        tick();
    endtask

    initial begin
        bus.alu_valid = 1'b0;
        bus.alu_rd    = '0;
        bus.alu_data  = '0;
        bus.ld_valid  = 1'b0;
        bus.ld_rd     = '0;
        bus.ld_funct3 = '0;
        bus.ld_off    = '0;
        bus.ld_word   = '0;

        // Reset
        tick();
        tick();
        chk("reset EN", 32'(bus.EN), 32'd0);
        chk("reset A3", 32'(bus.A3), 32'd0);
        chk("reset WD3", bus.WD3, 32'd0);
        chk("reset alu_ready", 32'(bus.alu_ready), 32'd0);
        chk("reset ld_ready", 32'(bus.ld_ready), 32'd0);
        RST_N = 1'b1;
        #1;
        chk("post-reset alu_ready", 32'(bus.alu_ready), 32'd1);

        // ALU write latency and single-cycle EN
        set_alu(5'd5, 32'h1234);
        tick();
        chk("alu EN", 32'(bus.EN), 32'd1);
        chk("alu A3", 32'(bus.A3), 32'd5);
        chk("alu WD3", bus.WD3, 32'h1234);
        idle();
        tick();
        chk("alu EN drop", 32'(bus.EN), 32'd0);

        // Load extension
        load_case("LB", 3'b000, 2'd2, 32'h0080FF00, 32'hFFFFFF80);
        load_case("LBU", 3'b100, 2'd2, 32'h0080FF00, 32'h00000080);
        load_case("LH", 3'b001, 2'd3, 32'h80010000, 32'hFFFF8001);
        load_case("LHU", 3'b101, 2'd1, 32'h0000F00D, 32'h0000F00D);

        // Starvation: two loads queued behind continuous ALU traffic
        set_alu(5'd10, 32'hA0A0A0A0);
        set_ld(5'd7, 3'b010, 2'd0, 32'h77);
        tick();
        set_ld(5'd8, 3'b010, 2'd0, 32'h88);
        tick();
        bus.ld_valid = 1'b0;
        chk("full ld_ready", 32'(bus.ld_ready), 32'd0);
        tick();
        tick();
        chk("starve alu_ready still high", 32'(bus.alu_ready), 32'd1);
        tick();
        chk("starve alu_ready low", 32'(bus.alu_ready), 32'd0);
        chk("starve pending", bus.pending_mask, 32'h0000_0580);
        tick();
        chk("starve pop7 EN", 32'(bus.EN), 32'd1);
        chk("starve pop7 A3", 32'(bus.A3), 32'd7);
        chk("starve pop7 WD3", bus.WD3, 32'h77);
        chk("starve pop7 pending", bus.pending_mask, 32'h0000_0180);
        chk("after pop ld_ready", 32'(bus.ld_ready), 32'd1);
        tick();
        chk("bit7 cleared", bus.pending_mask, 32'h0000_0500);
        repeat (4) tick();
        chk("starve pop8 A3", 32'(bus.A3), 32'd8);
        chk("starve pop8 WD3", bus.WD3, 32'h88);
        idle();
        tick();
        chk("starve drained pending", bus.pending_mask, 32'd0);

        // Full queue, then a third load arriving while a slot frees up
        set_alu(5'd11, 32'h11);
        set_ld(5'd12, 3'b010, 2'd0, 32'hC0DE0012);
        tick();
        set_ld(5'd13, 3'b010, 2'd0, 32'hC0DE0013);
        tick();
        chk("full2 ld_ready", 32'(bus.ld_ready), 32'd0);
        set_ld(5'd14, 3'b010, 2'd0, 32'hC0DE0014);
        bus.alu_valid = 1'b0;
        tick();
        chk("full2 pop12 A3", 32'(bus.A3), 32'd12);
        chk("full2 ld_ready back", 32'(bus.ld_ready), 32'd1);
        tick();
        bus.ld_valid = 1'b0;
        chk("full2 pop13 A3", 32'(bus.A3), 32'd13);
        tick();
        chk("full2 pop14 A3", 32'(bus.A3), 32'd14);
        chk("full2 pop14 WD3", bus.WD3, 32'hC0DE0014);
        tick();

        // rd=0 traffic
        set_alu(5'd0, 32'hDEAD);
        set_ld(5'd0, 3'b010, 2'd0, 32'hBEEF);
        repeat (3) begin
            tick();
            chk("rd0 EN", 32'(bus.EN), 32'd0);
            chk("rd0 pending", bus.pending_mask, 32'd0);
        end
        idle();
        tick();
        chk("rd0 nothing queued EN", 32'(bus.EN), 32'd0);

        // Reset with two loads queued
        set_alu(5'd9, 32'h99);
        set_ld(5'd20, 3'b010, 2'd0, 32'h20);
        tick();
        set_ld(5'd21, 3'b010, 2'd0, 32'h21);
        tick();
        idle();
        RST_N = 1'b0;
        tick();
        chk("midreset EN", 32'(bus.EN), 32'd0);
        chk("midreset pending", bus.pending_mask, 32'd0);
        chk("midreset ld_ready", 32'(bus.ld_ready), 32'd0);
        RST_N = 1'b1;
        repeat (3) begin
            tick();
            chk("post midreset EN", 32'(bus.EN), 32'd0);
        end

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            bus.alu_valid = ($urandom_range(0, 99) < 60);
            bus.alu_rd    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            bus.alu_data  = $urandom;
            bus.ld_valid  = ($urandom_range(0, 99) < 45);
            bus.ld_rd     = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            bus.ld_funct3 = 3'($urandom_range(0, 7));
            bus.ld_off    = 2'($urandom_range(0, 3));
            bus.ld_word   = $urandom;
            RST_N         = ($urandom_range(0, 299) != 0);
            tick();
        end
        RST_N = 1'b1;
        idle();
        repeat (10) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
